// File: rtl/control_unit.sv
// control_unit: registered instruction decoder.
// The opcode sampled at each rising clock edge is decoded into the datapath
// control signals, which appear one cycle later and hold for a full cycle.
// A synchronous reset takes priority and zeroes every control output.
// The block keeps no state besides the output register.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    output logic       MemToReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       Jump,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic [2:0] ALUOp
);

    // Opcode map
    localparam logic [4:0] OP_LOADR   = 5'b00000;
    localparam logic [4:0] OP_STOREB  = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00011;
    localparam logic [4:0] OP_ADDI    = 5'b00100;
    localparam logic [4:0] OP_SUB     = 5'b00101;
    localparam logic [4:0] OP_SUBI    = 5'b00110;
    localparam logic [4:0] OP_MUL     = 5'b01001;
    localparam logic [4:0] OP_DIV     = 5'b01010;
    localparam logic [4:0] OP_MLS     = 5'b01011;
    localparam logic [4:0] OP_SWI     = 5'b01100;
    localparam logic [4:0] OP_PUSH    = 5'b01101;
    localparam logic [4:0] OP_POP     = 5'b01110;
    localparam logic [4:0] OP_J       = 5'b01111;
    localparam logic [4:0] OP_JL      = 5'b10000;
    localparam logic [4:0] OP_CMP     = 5'b10001;
    localparam logic [4:0] OP_BEQ     = 5'b10010;
    localparam logic [4:0] OP_BNE     = 5'b10011;
    localparam logic [4:0] OP_BX      = 5'b10100;
    localparam logic [4:0] OP_STOREBI = 5'b10101;
    localparam logic [4:0] OP_LDRBR   = 5'b10110;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_MLS = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;

    typedef struct packed {
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       branch_eq;
        logic       branch_ne;
        logic [2:0] alu_op;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Combinational decode of the incoming opcode; anything unlisted is a NOP.
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_LOADR, OP_POP: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            OP_LDRBR: begin
                // Register-offset load: address offset comes from a register.
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            OP_STOREB, OP_PUSH, OP_STOREBI: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            OP_ADD: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            OP_SUBI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            OP_MUL: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_MUL;
            end
            OP_DIV: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_DIV;
            end
            OP_MLS: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_MLS;
            end
            OP_SWI: begin
                // Software interrupt is trapped outside this block.
                ctrl_d = '0;
            end
            OP_J, OP_BX: begin
                ctrl_d.jump = 1'b1;
            end
            OP_JL: begin
                // Jump-and-link writes the return address to the link register.
                ctrl_d.jump      = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OP_CMP: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.alu_op  = ALU_CMP;
            end
            OP_BEQ: begin
                ctrl_d.branch_eq = 1'b1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_d.branch_ne = 1'b1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    // Output register; reset overrides the decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign MemToReg = ctrl_q.mem_to_reg;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign ALUSrc   = ctrl_q.alu_src;
    assign RegWrite = ctrl_q.reg_write;
    assign Jump     = ctrl_q.jump;
    assign BranchEQ = ctrl_q.branch_eq;
    assign BranchNE = ctrl_q.branch_ne;
    assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for the registered instruction decoder.
// Control word layout used throughout the bench (11 bits):
//   {MemToReg, MemRead, MemWrite, ALUSrc, RegWrite}_{Jump, BranchEQ, BranchNE}_{ALUOp}
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic       MemToReg;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic       BranchEQ;
  logic       BranchNE;
  logic [2:0] ALUOp;

  int checks;
  int failures;
  bit model_on;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .MemToReg (MemToReg),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .Jump     (Jump),
    .BranchEQ (BranchEQ),
    .BranchNE (BranchNE),
    .ALUOp    (ALUOp)
  );

  wire [10:0] dut_w = {MemToReg, MemRead, MemWrite, ALUSrc, RegWrite,
                       Jump, BranchEQ, BranchNE, ALUOp};

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Each output is defined as membership of the opcode in the set of
  // instructions that assert it; reset forces every output low.
  function automatic logic [10:0] model(input logic r, input logic [4:0] op);
    logic       m2r, mrd, mwr, asrc, rw, jmp, beq, bne;
    logic [2:0] aop;
    m2r  = op inside {5'h00, 5'h0E, 5'h16};
    mrd  = op inside {5'h00, 5'h0E, 5'h16};
    mwr  = op inside {5'h01, 5'h0D, 5'h15};
    asrc = op inside {5'h00, 5'h01, 5'h04, 5'h06, 5'h0D, 5'h0E, 5'h11, 5'h15};
    rw   = op inside {5'h00, 5'h03, 5'h04, 5'h05, 5'h06, 5'h09, 5'h0A,
                      5'h0B, 5'h0E, 5'h10, 5'h16};
    jmp  = op inside {5'h0F, 5'h10, 5'h14};
    beq  = (op == 5'h12);
    bne  = (op == 5'h13);
    if (op inside {5'h05, 5'h06, 5'h12, 5'h13}) aop = 3'd1;
    else if (op == 5'h09) aop = 3'd2;
    else if (op == 5'h0A) aop = 3'd3;
    else if (op == 5'h0B) aop = 3'd4;
    else if (op == 5'h11) aop = 3'd5;
    else aop = 3'd0;
    if (r) return 11'b0;
    return {m2r, mrd, mwr, asrc, rw, jmp, beq, bne, aop};
  endfunction

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Model samples inputs at each edge; the compare runs just after the edge.
  always @(posedge clk) begin
    if (model_on) begin
      logic [10:0] exp_w;
      exp_q.push_back(model(rst, opcode));
      #2;
      exp_w = exp_q.pop_front();
      check("model_cmp", dut_w, exp_w);
      checks++;
      if ((32'(Jump) + 32'(BranchEQ) + 32'(BranchNE)) > 1 || (MemRead && MemWrite)) begin
        failures++;
        $display("FAIL exclusivity word=%b", dut_w);
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic        r;
    logic [4:0]  op;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [4:0] op, input logic [10:0] e, input string n);
    vec_t v;
    v.r = r; v.op = op; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [4:0] op);
    @(negedge clk);
    rst    = r;
    opcode = op;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_on = 1'b0;
    rst      = 1'b1;
    opcode   = 5'b00000;

    // Hand-computed vectors (expected word one cycle after the opcode).
    add_vec(1, 5'b00000, 11'b00000_000_000, "reset_loadr");
    add_vec(0, 5'b00000, 11'b11011_000_000, "loadr");
    add_vec(0, 5'b00011, 11'b00001_000_000, "add");
    add_vec(0, 5'b00100, 11'b00011_000_000, "addi");
    add_vec(0, 5'b00101, 11'b00001_000_001, "sub");
    add_vec(0, 5'b00110, 11'b00011_000_001, "subi");
    add_vec(0, 5'b01001, 11'b00001_000_010, "mul");
    add_vec(0, 5'b01010, 11'b00001_000_011, "div");
    add_vec(0, 5'b01011, 11'b00001_000_100, "mls");
    add_vec(0, 5'b10001, 11'b00010_000_101, "cmp");
    add_vec(0, 5'b01111, 11'b00000_100_000, "j");
    add_vec(0, 5'b10000, 11'b00001_100_000, "jl");
    add_vec(0, 5'b10100, 11'b00000_100_000, "bx");
    add_vec(0, 5'b10010, 11'b00000_010_001, "beq");
    add_vec(0, 5'b10011, 11'b00000_001_001, "bne");
    add_vec(0, 5'b00001, 11'b00110_000_000, "storeb");
    add_vec(0, 5'b10101, 11'b00110_000_000, "storebi");
    add_vec(0, 5'b01101, 11'b00110_000_000, "push");
    add_vec(0, 5'b01110, 11'b11011_000_000, "pop");
    add_vec(0, 5'b10110, 11'b11001_000_000, "ldrbr");
    add_vec(0, 5'b01100, 11'b00000_000_000, "swi");
    add_vec(0, 5'b11111, 11'b00000_000_000, "nop_11111");
    add_vec(1, 5'b00011, 11'b00000_000_000, "reset_add");
    add_vec(0, 5'b00011, 11'b00001_000_000, "add_after_reset");
    add_vec(0, 5'b00010, 11'b00000_000_000, "nop_00010");
    add_vec(0, 5'b00111, 11'b00000_000_000, "nop_00111");
    add_vec(0, 5'b01000, 11'b00000_000_000, "nop_01000");
    add_vec(0, 5'b10111, 11'b00000_000_000, "nop_10111");
    add_vec(1, 5'b01111, 11'b00000_000_000, "reset_j");
    add_vec(0, 5'b10010, 11'b00000_010_001, "beq_after_reset");

    // Apply directed vectors, checking DUT and model against the literals.
    @(negedge clk);
    model_on = 1'b1;
    foreach (vecs[i]) begin
      rst    = vecs[i].r;
      opcode = vecs[i].op;
      @(posedge clk);
      #1;
      check(vecs[i].name, dut_w, vecs[i].exp);
      check({vecs[i].name, "_model"}, model(vecs[i].r, vecs[i].op), vecs[i].exp);
      @(negedge clk);
    end

    // Back-to-back sweep of every opcode, with one reset pulse in the middle.
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'(k));
      if (k == 16) drive(1'b1, 5'(k));
    end
    for (int k = 31; k >= 0; k--) begin
      drive(1'b0, 5'(k));
    end
    drive(1'b0, 5'b00000);
    @(negedge clk);
    model_on = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset named clk and rst.
REQ-002 clk  input  1  rising-edge clock; all outputs update only on this edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  5  instruction opcode to decode.
REQ-005 MemToReg  output  1  writeback source is memory data (1) or ALU result (0).
REQ-006 MemRead  output  1  data-memory read enable.
REQ-007 MemWrite  output  1  data-memory write enable.
REQ-008 ALUSrc  output  1  ALU operand B is immediate (1) or register (0).
REQ-009 RegWrite  output  1  register-file write enable.
REQ-010 Jump  output  1  unconditional PC redirect.
REQ-011 BranchEQ  output  1  branch if ALU zero flag is set.
REQ-012 BranchNE  output  1  branch if ALU zero flag is clear.
REQ-013 ALUOp  output  3  ALU operation: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MLS, 101 CMP, others reserved.

Function
REQ-014 All outputs SHALL be registered: the decode of opcode sampled at rising edge N SHALL appear on the outputs after edge N and hold until edge N+1 (latency 1 cycle).
REQ-015 Any output not listed for an opcode in REQ-016..REQ-034 SHALL be 0; ALUOp SHALL be 000 unless stated.
REQ-016 00000 LOADR: MemToReg=1, MemRead=1, ALUSrc=1, RegWrite=1, ALUOp=000.
REQ-017 00001 STOREB: MemWrite=1, ALUSrc=1, ALUOp=000.
REQ-018 00011 ADD: RegWrite=1, ALUSrc=0, ALUOp=000.
REQ-019 00100 ADDI: RegWrite=1, ALUSrc=1, ALUOp=000.
REQ-020 00101 SUB: RegWrite=1, ALUSrc=0, ALUOp=001.
REQ-021 00110 SUBI: RegWrite=1, ALUSrc=1, ALUOp=001.
REQ-022 01001 MUL: RegWrite=1, ALUOp=010.
REQ-023 01010 DIV: RegWrite=1, ALUOp=011.
REQ-024 01011 MLS: RegWrite=1, ALUOp=100.
REQ-025 01100 SWI: all outputs 0 (trap handled outside this block).
REQ-026 01101 PUSH: MemWrite=1, ALUSrc=1, ALUOp=000.
REQ-027 01110 POP: MemRead=1, MemToReg=1, ALUSrc=1, RegWrite=1, ALUOp=000.
REQ-028 01111 J: Jump=1.
REQ-029 10000 JL: Jump=1, RegWrite=1 (link register write).
REQ-030 10001 CMP: ALUSrc=1, ALUOp=101, RegWrite=0.
REQ-031 10010 BEQ: BranchEQ=1, ALUOp=001.
REQ-032 10011 BNE: BranchNE=1, ALUOp=001.
REQ-033 10100 BX: Jump=1, RegWrite=0.
REQ-034 10101 STOREBI: MemWrite=1, ALUSrc=1, ALUOp=000; 10110 LDRBR: MemToReg=1, MemRead=1, ALUSrc=0, RegWrite=1, ALUOp=000.
REQ-035 Unassigned opcodes (00010, 00111, 01000, 10111-11111) SHALL decode as NOP: all outputs 0.
REQ-036 At most one of Jump, BranchEQ, BranchNE SHALL be 1 in any cycle; MemRead and MemWrite SHALL never both be 1.
REQ-037 An X/Z opcode is not a supported input; the outputs are unspecified for such input.

Reset
REQ-038 At a rising edge with rst=1, all outputs SHALL become 0 regardless of opcode; rst has priority over decode.
REQ-039 At the first rising edge with rst=0, the outputs SHALL reflect the opcode sampled at that edge; no other state is retained.
REQ-040 Asserting rst mid-sequence SHALL zero the outputs at the next edge without affecting later decodes.

Verification
REQ-041 rst=1, opcode=00000, one edge -> all outputs 0; then rst=0, one edge -> MemToReg=1, MemRead=1, MemWrite=0, ALUSrc=1, RegWrite=1.
REQ-042 opcode sequence 00011, 00100, 00101, 00110 -> ALUOp/ALUSrc/RegWrite = 000/0/1, 000/1/1, 001/0/1, 001/1/1, each one cycle after its opcode.
REQ-043 opcode 01001, 01010, 01011, 10001 -> ALUOp 010, 011, 100, 101; RegWrite 1, 1, 1, 0.
REQ-044 opcode 01111, 10000, 10100, 10010, 10011 -> Jump/RegWrite 1/0, 1/1, 1/0; BranchEQ=1 only for 10010; BranchNE=1 only for 10011.
REQ-045 opcode 00001, 10101, 01101 -> MemWrite=1, RegWrite=0; opcode 01110, 10110 -> MemRead=1, RegWrite=1; opcode 01100 and 11111 -> all outputs 0.
REQ-046 rst=1 while opcode=00011 held -> all outputs 0 at that edge; release rst -> ALUOp=000, RegWrite=1 at the next edge.
